// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus: mem_access_stage is the master, the data memory the slave.
interface mem_access_stage_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// EX/MEM register plus data-memory access with load alignment, stall and access timeout.
// Optional MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW raise o_misalign_exc instead of accessing memory.
module mem_access_stage #(
    parameter int XLEN         = 32,
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid_EXE,
    input  logic [XLEN-1:0] i_alu_result_EXE,
    input  logic [XLEN-1:0] i_store_data_EXE,
    input  logic [4:0]      i_rd_EXE,
    input  logic            i_reg_write_EXE,
    input  logic            i_mem_read_EXE,
    input  logic            i_mem_write_EXE,
    input  logic [2:0]      i_funct3_EXE,
    input  logic            i_flush,
    mem_access_stage_if.master dmem,
    output logic            o_mem_stall,
    output logic [XLEN-1:0] o_fwd_data_MEM,
    output logic [4:0]      o_rd_MEM,
    output logic            o_wb_valid,
    output logic            o_wb_reg_write,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
`ifdef MISALIGN_TRAP_EN
    output logic            o_misalign_exc,
`endif
    output logic            o_bus_err
);

    localparam int CW = $clog2(DMEM_TIMEOUT) + 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_wait_cnt;

    logic            r_valid_M;
    logic [XLEN-1:0] r_alu_M;
    logic [XLEN-1:0] r_store_M;
    logic [4:0]      r_rd_M;
    logic            r_reg_write_M;
    logic            r_mem_read_M;
    logic            r_mem_write_M;
    logic [2:0]      r_funct3_M;

    logic            r_wb_valid;
    logic            r_wb_reg_write;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;

    logic            w_mem_op;
    logic            w_misalign;
    logic            w_req;
    logic            w_timeout;
    logic            w_stall;
    logic [1:0]      w_off;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_lane_data;
    logic [XLEN-1:0] w_load_data;

    assign w_mem_op = r_valid_M & (r_mem_read_M | r_mem_write_M);

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (r_funct3_M[1:0])
            2'b01:   w_misalign = w_mem_op & r_alu_M[0];
            2'b10:   w_misalign = w_mem_op & (r_alu_M[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end
    assign o_misalign_exc = w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req = w_mem_op & ~w_misalign;

    // Address bits below the access size are dropped, so the lane is always size-aligned.
    always_comb begin
        case (r_funct3_M[1:0])
            2'b00:   w_off = r_alu_M[1:0];
            2'b01:   w_off = {r_alu_M[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    always_comb begin
        case (r_funct3_M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {(XLEN/8){r_store_M[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {(XLEN/16){r_store_M[15:0]}};
            end
            default: begin
                w_be    = 4'hF;
                w_wdata = r_store_M;
            end
        endcase
    end

    assign w_lane_data = dmem.rdata >> {w_off, 3'b000};

    always_comb begin
        case (r_funct3_M)
            3'b000:  w_load_data = {{(XLEN-8){w_lane_data[7]}}, w_lane_data[7:0]};
            3'b001:  w_load_data = {{(XLEN-16){w_lane_data[15]}}, w_lane_data[15:0]};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_lane_data[7:0]};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_lane_data[15:0]};
            default: w_load_data = w_lane_data;
        endcase
    end

    // Wait counter holds the number of cycles the current request has already stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_stall ? r_wait_cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_req & ~dmem.ack) w_next_state = S_WAIT;
            S_WAIT:  if (~w_req | dmem.ack | w_timeout) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_timeout = (r_state == S_WAIT) & w_req & ~dmem.ack &
                    (r_wait_cnt == CW'(DMEM_TIMEOUT - 1));
        w_stall   = w_req & ~dmem.ack & ~w_timeout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid_M     <= 1'b0;
            r_alu_M       <= '0;
            r_store_M     <= '0;
            r_rd_M        <= '0;
            r_reg_write_M <= 1'b0;
            r_mem_read_M  <= 1'b0;
            r_mem_write_M <= 1'b0;
            r_funct3_M    <= '0;
        end else if (!w_stall) begin
            r_valid_M     <= i_valid_EXE & ~i_flush;
            r_alu_M       <= i_alu_result_EXE;
            r_store_M     <= i_store_data_EXE;
            r_rd_M        <= i_rd_EXE;
            r_reg_write_M <= i_reg_write_EXE;
            r_mem_read_M  <= i_mem_read_EXE;
            r_mem_write_M <= i_mem_write_EXE;
            r_funct3_M    <= i_funct3_EXE;
        end
    end

    // Timed-out and trapped accesses still leave MEM, but retire as bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
        end else if (!w_stall) begin
            r_wb_valid     <= r_valid_M & ~w_timeout & ~w_misalign;
            r_wb_reg_write <= r_valid_M & r_reg_write_M & ~r_mem_write_M & ~w_timeout & ~w_misalign;
            r_wb_rd        <= r_rd_M;
            r_wb_data      <= r_mem_read_M ? w_load_data : r_alu_M;
        end
    end

    assign dmem.req       = w_req;
    assign dmem.we        = r_mem_write_M;
    assign dmem.addr      = {r_alu_M[XLEN-1:2], 2'b00};
    assign dmem.be        = w_be;
    assign dmem.wdata     = w_wdata;

    assign o_mem_stall    = w_stall;
    assign o_fwd_data_MEM = r_alu_M;
    assign o_rd_MEM       = r_rd_M;
    assign o_wb_valid     = r_wb_valid;
    assign o_wb_reg_write = r_wb_reg_write;
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_data      = r_wb_data;
    assign o_bus_err      = w_timeout;

endmodule
